// File: rtl/voice_alloc_if.sv
// voice_alloc_if: event handshake, voice-done feedback and voice configuration bus of voice_alloc.
// The slave modport is the scheduler's view; master is the event source / voice datapath side.
interface voice_alloc_if #(
    parameter int NUM_VOICES = 8
);
    localparam int IDX_W = $clog2(NUM_VOICES);

    logic             ev_valid;
    logic             ev_ready;
    logic             ev_on;
    logic [6:0]       ev_key;
    logic [6:0]       ev_vel;
    logic             voice_done;
    logic [IDX_W-1:0] voice_done_idx;
    logic             voice_we;
    logic [IDX_W-1:0] voice_idx;
    logic [6:0]       voice_key;
    logic [6:0]       voice_vel;
    logic             voice_gate;
    logic [4:0]       active_count;
    logic [15:0]      drop_count;

    modport master (
        output ev_valid, ev_on, ev_key, ev_vel, voice_done, voice_done_idx,
        input  ev_ready, voice_we, voice_idx, voice_key, voice_vel, voice_gate,
               active_count, drop_count
    );

    modport slave (
        input  ev_valid, ev_on, ev_key, ev_vel, voice_done, voice_done_idx,
        output ev_ready, voice_we, voice_idx, voice_key, voice_vel, voice_gate,
               active_count, drop_count
    );
endinterface

// File: rtl/voice_alloc.sv
// voice_alloc: polyphony scheduler that assigns, retriggers, releases and steals synth voices.
// Optional macro VOICE_STEAL_EN: steal the oldest held voice when no free or releasing voice exists.
module voice_alloc #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    voice_alloc_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [1:0] VS_FREE = 2'd0;
    localparam logic [1:0] VS_HELD = 2'd1;
    localparam logic [1:0] VS_REL  = 2'd2;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (&a) ? a : a + AGE_W'(1);
    endfunction

    function automatic logic [15:0] drop_inc(input logic [15:0] d);
        return (&d) ? d : d + 16'd1;
    endfunction

    logic [1:0]       state_q;
    logic             rdy_q;
    logic [IDX_W-1:0] scan_q;
    logic             on_q;
    logic [6:0]       key_q;
    logic [6:0]       vel_q;

    logic [1:0]       vst_q  [NUM_VOICES];
    logic [6:0]       vkey_q [NUM_VOICES];
    logic [AGE_W-1:0] vage_q [NUM_VOICES];
    logic [1:0]       vst_n  [NUM_VOICES];
    logic [6:0]       vkey_n [NUM_VOICES];
    logic [AGE_W-1:0] vage_n [NUM_VOICES];

    logic             m_f_q, m_held_q, fr_f_q, rl_f_q, hd_f_q;
    logic [IDX_W-1:0] m_idx_q, fr_idx_q, rl_idx_q, hd_idx_q;
    logic [AGE_W-1:0] rl_age_q, hd_age_q;
    logic             m_f_n, m_held_n, fr_f_n, rl_f_n, hd_f_n;
    logic [IDX_W-1:0] m_idx_n, fr_idx_n, rl_idx_n, hd_idx_n;
    logic [AGE_W-1:0] rl_age_n, hd_age_n;

    logic [1:0]       cur_st;
    logic [6:0]       cur_key;
    logic [AGE_W-1:0] cur_age;

    logic             t_f;
    logic [IDX_W-1:0] t_idx;
    logic             tgt_f_q;
    logic [IDX_W-1:0] tgt_idx_q;

    logic             we_q;
    logic [IDX_W-1:0] idx_q;
    logic [6:0]       okey_q;
    logic [6:0]       ovel_q;
    logic             gate_q;
    logic [4:0]       active_q;
    logic [4:0]       active_n;
    logic [15:0]      drop_q;

    // Scan stage: fold the voice under the scan index into the running decision.
    always_comb begin
        cur_st   = vst_q[scan_q];
        cur_key  = vkey_q[scan_q];
        cur_age  = vage_q[scan_q];
        m_f_n    = m_f_q;
        m_held_n = m_held_q;
        m_idx_n  = m_idx_q;
        fr_f_n   = fr_f_q;
        fr_idx_n = fr_idx_q;
        rl_f_n   = rl_f_q;
        rl_idx_n = rl_idx_q;
        rl_age_n = rl_age_q;
        hd_f_n   = hd_f_q;
        hd_idx_n = hd_idx_q;
        hd_age_n = hd_age_q;
        if (cur_st != VS_FREE && cur_key == key_q && !m_f_q) begin
            m_f_n    = 1'b1;
            m_held_n = (cur_st == VS_HELD);
            m_idx_n  = scan_q;
        end
        if (cur_st == VS_FREE && !fr_f_q) begin
            fr_f_n   = 1'b1;
            fr_idx_n = scan_q;
        end
        if (cur_st == VS_REL && (!rl_f_q || cur_age > rl_age_q)) begin
            rl_f_n   = 1'b1;
            rl_idx_n = scan_q;
            rl_age_n = cur_age;
        end
        if (cur_st == VS_HELD && (!hd_f_q || cur_age > hd_age_q)) begin
            hd_f_n   = 1'b1;
            hd_idx_n = scan_q;
            hd_age_n = cur_age;
        end
    end

    // Target selection from the decision including the final scanned voice.
    always_comb begin
        t_f   = 1'b0;
        t_idx = '0;
        if (on_q) begin
            if (m_f_n) begin
                t_f   = 1'b1;
                t_idx = m_idx_n;
            end else if (fr_f_n) begin
                t_f   = 1'b1;
                t_idx = fr_idx_n;
            end else if (rl_f_n) begin
                t_f   = 1'b1;
                t_idx = rl_idx_n;
            end
`ifdef VOICE_STEAL_EN
            else if (hd_f_n) begin
                t_f   = 1'b1;
                t_idx = hd_idx_n;
            end
`endif
        end else if (m_f_n && m_held_n) begin
            t_f   = 1'b1;
            t_idx = m_idx_n;
        end
    end

    // Table update: done pulses first, then the commit result overrides for its target.
    always_comb begin
        active_n = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            vst_n[v]  = vst_q[v];
            vkey_n[v] = vkey_q[v];
            vage_n[v] = vage_q[v];
            if (bus.voice_done && bus.voice_done_idx == IDX_W'(v) && vst_q[v] == VS_REL)
                vst_n[v] = VS_FREE;
            if (state_q == ST_COMMIT) begin
                if (on_q) begin
                    if (tgt_f_q && tgt_idx_q == IDX_W'(v)) begin
                        vst_n[v]  = VS_HELD;
                        vkey_n[v] = key_q;
                        vage_n[v] = '0;
                    end else if (vst_n[v] != VS_FREE) begin
                        vage_n[v] = age_inc(vage_q[v]);
                    end
                end else if (tgt_f_q && tgt_idx_q == IDX_W'(v)) begin
                    vst_n[v] = VS_REL;
                end
            end
            active_n = active_n + 5'(vst_n[v] != VS_FREE);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            rdy_q     <= 1'b0;
            scan_q    <= '0;
            on_q      <= 1'b0;
            key_q     <= '0;
            vel_q     <= '0;
            m_f_q     <= 1'b0;
            m_held_q  <= 1'b0;
            m_idx_q   <= '0;
            fr_f_q    <= 1'b0;
            fr_idx_q  <= '0;
            rl_f_q    <= 1'b0;
            rl_idx_q  <= '0;
            rl_age_q  <= '0;
            hd_f_q    <= 1'b0;
            hd_idx_q  <= '0;
            hd_age_q  <= '0;
            tgt_f_q   <= 1'b0;
            tgt_idx_q <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            okey_q    <= '0;
            ovel_q    <= '0;
            gate_q    <= 1'b0;
            active_q  <= '0;
            drop_q    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                vst_q[v]  <= VS_FREE;
                vkey_q[v] <= '0;
                vage_q[v] <= '0;
            end
        end else begin
            we_q     <= 1'b0;
            vst_q    <= vst_n;
            vkey_q   <= vkey_n;
            vage_q   <= vage_n;
            active_q <= active_n;
            case (state_q)
                ST_IDLE: begin
                    rdy_q <= 1'b1;
                    if (bus.ev_valid && rdy_q) begin
                        rdy_q   <= 1'b0;
                        on_q    <= bus.ev_on && (bus.ev_vel != 7'd0);
                        key_q   <= bus.ev_key;
                        vel_q   <= bus.ev_vel;
                        scan_q  <= '0;
                        m_f_q   <= 1'b0;
                        fr_f_q  <= 1'b0;
                        rl_f_q  <= 1'b0;
                        hd_f_q  <= 1'b0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    m_f_q    <= m_f_n;
                    m_held_q <= m_held_n;
                    m_idx_q  <= m_idx_n;
                    fr_f_q   <= fr_f_n;
                    fr_idx_q <= fr_idx_n;
                    rl_f_q   <= rl_f_n;
                    rl_idx_q <= rl_idx_n;
                    rl_age_q <= rl_age_n;
                    hd_f_q   <= hd_f_n;
                    hd_idx_q <= hd_idx_n;
                    hd_age_q <= hd_age_n;
                    scan_q   <= scan_q + IDX_W'(1);
                    if (scan_q == LAST_IDX) begin
                        state_q   <= ST_COMMIT;
                        tgt_f_q   <= t_f;
                        tgt_idx_q <= t_idx;
                        if (t_f) begin
                            we_q   <= 1'b1;
                            idx_q  <= t_idx;
                            okey_q <= key_q;
                            ovel_q <= on_q ? vel_q : 7'd0;
                            gate_q <= on_q;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                    if (on_q && !tgt_f_q)
                        drop_q <= drop_inc(drop_q);
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A reset landing in the commit cycle suppresses the strobe already on the bus.
    assign bus.ev_ready     = rdy_q;
    assign bus.voice_we     = we_q & ~RESET;
    assign bus.voice_idx    = idx_q;
    assign bus.voice_key    = okey_q;
    assign bus.voice_vel    = ovel_q;
    assign bus.voice_gate   = gate_q;
    assign bus.active_count = active_q;
    assign bus.drop_count   = drop_q;
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: table vectors, hand-written corner sequences and randomized events
// checked against an array-based behavioural model of the voice pool.
module tb_voice_alloc;
    localparam int NV = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    voice_alloc_if #(.NUM_VOICES(NV)) bus ();

    voice_alloc #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0 free, 1 held, 2 releasing.
    int m_st  [NV];
    int m_key [NV];
    int m_age [NV];
    int m_drop;

    // Expected and observed results of the last event.
    bit x_we, x_gate;
    int x_idx, x_key, x_vel;
    bit g_we, g_gate;
    int g_idx, g_key, g_vel, g_we_lat, g_rdy_lat, g_we_cnt;

    typedef struct {
        bit is_done;
        bit on;
        int key;
        int vel;
        bit we;
        int idx;
        int okey;
        int ovel;
        bit gate;
        int act;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_st[i] = 0; m_key[i] = 0; m_age[i] = 0;
        end
        m_drop = 0;
    endtask

    function automatic int model_active();
        int n = 0;
        for (int i = 0; i < NV; i++) if (m_st[i] != 0) n++;
        return n;
    endfunction

    function automatic int oldest(input int s);
        int best = -1;
        for (int i = 0; i < NV; i++)
            if (m_st[i] == s && (best < 0 || m_age[i] > m_age[best])) best = i;
        return best;
    endfunction

    task automatic model_event(input bit on, input int key, input int vel);
        int m = -1;
        int t = -1;
        x_we = 0; x_idx = 0; x_key = 0; x_vel = 0; x_gate = 0;
        for (int i = 0; i < NV; i++) if (m < 0 && m_st[i] != 0 && m_key[i] == key) m = i;
        if (on && vel != 0) begin
            if (m >= 0) t = m;
            for (int i = 0; i < NV; i++) if (t < 0 && m_st[i] == 0) t = i;
            if (t < 0) t = oldest(2);
`ifdef VOICE_STEAL_EN
            if (t < 0) t = oldest(1);
`endif
            for (int i = 0; i < NV; i++)
                if (i != t && m_st[i] != 0 && m_age[i] < 255) m_age[i]++;
            if (t >= 0) begin
                m_st[t] = 1; m_key[t] = key; m_age[t] = 0;
                x_we = 1; x_idx = t; x_key = key; x_vel = vel; x_gate = 1;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end else if (m >= 0 && m_st[m] == 1) begin
            m_st[m] = 2;
            x_we = 1; x_idx = m; x_key = key; x_vel = 0; x_gate = 0;
        end
    endtask

    task automatic send_event(input bit on, input int key, input int vel);
        int n = 0;
        while (!bus.ev_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", bus.ev_ready, 1);
        bus.ev_valid = 1'b1;
        bus.ev_on    = on;
        bus.ev_key   = 7'(key);
        bus.ev_vel   = 7'(vel);
        @(posedge clk); #1;
        bus.ev_valid = 1'b0;
        g_we = 0; g_we_lat = -1; g_rdy_lat = -1; g_we_cnt = 0;
        g_idx = 0; g_key = 0; g_vel = 0; g_gate = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.voice_we) begin
                g_we_cnt++;
                if (!g_we) begin
                    g_we = 1; g_we_lat = i;
                    g_idx = int'(bus.voice_idx); g_key = int'(bus.voice_key);
                    g_vel = int'(bus.voice_vel); g_gate = bus.voice_gate;
                end
            end
            if (bus.ev_ready) begin
                g_rdy_lat = i;
                break;
            end
        end
    endtask

    task automatic pulse_done(input int idx);
        bus.voice_done     = 1'b1;
        bus.voice_done_idx = 3'(idx);
        @(posedge clk); #1;
        bus.voice_done     = 1'b0;
        if (m_st[idx] == 2) m_st[idx] = 0;
    endtask

    task automatic run_model(input string tag, input bit on, input int key, input int vel);
        model_event(on, key, vel);
        send_event(on, key, vel);
        chk({tag, "_we"}, g_we, x_we);
        chk({tag, "_we_cnt"}, g_we_cnt, x_we);
        if (x_we) begin
            chk({tag, "_idx"}, g_idx, x_idx);
            chk({tag, "_key"}, g_key, x_key);
            chk({tag, "_vel"}, g_vel, x_vel);
            chk({tag, "_gate"}, g_gate, x_gate);
            chk({tag, "_we_lat"}, g_we_lat, NV);
        end
        chk({tag, "_rdy_lat"}, g_rdy_lat, NV + 1);
        chk({tag, "_active"}, bus.active_count, model_active());
        chk({tag, "_drop"}, bus.drop_count, m_drop);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ev_valid = 1'b0;
        bus.voice_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.ev_ready, 0);
        chk("rst_we", bus.voice_we, 0);
        chk("rst_idx", bus.voice_idx, 0);
        chk("rst_key", bus.voice_key, 0);
        chk("rst_vel", bus.voice_vel, 0);
        chk("rst_gate", bus.voice_gate, 0);
        chk("rst_active", bus.active_count, 0);
        chk("rst_drop", bus.drop_count, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready_after", bus.ev_ready, 1);
        model_clear();
    endtask

    int wcnt;
    int d;
    bit r_on;
    int r_key, r_vel;

    initial begin
        reset = 1'b1;
        bus.ev_valid = 1'b0; bus.ev_on = 1'b0; bus.ev_key = '0; bus.ev_vel = '0;
        bus.voice_done = 1'b0; bus.voice_done_idx = '0;

        vecs[0]  = '{0, 1, 60, 100, 1, 0, 60, 100, 1, 1};
        vecs[1]  = '{0, 1, 60, 110, 1, 0, 60, 110, 1, 1};
        vecs[2]  = '{0, 1, 64,  90, 1, 1, 64,  90, 1, 2};
        vecs[3]  = '{0, 1, 67,  80, 1, 2, 67,  80, 1, 3};
        vecs[4]  = '{0, 0, 64,  50, 1, 1, 64,   0, 0, 3};
        vecs[5]  = '{1, 0,  0,   0, 0, 1,  0,   0, 0, 2};
        vecs[6]  = '{0, 1, 72,  70, 1, 1, 72,  70, 1, 3};
        vecs[7]  = '{0, 1, 67,   0, 1, 2, 67,   0, 0, 3};
        vecs[8]  = '{0, 0, 99,  10, 0, 0,  0,   0, 0, 3};
        vecs[9]  = '{0, 0, 67,  10, 0, 0,  0,   0, 0, 3};
        vecs[10] = '{1, 0,  0,   0, 0, 2,  0,   0, 0, 2};
        vecs[11] = '{1, 0,  0,   0, 0, 0,  0,   0, 0, 2};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_done) begin
                pulse_done(vecs[i].idx);
                chk("tbl_done_active", bus.active_count, vecs[i].act);
            end else begin
                model_event(vecs[i].on, vecs[i].key, vecs[i].vel);
                send_event(vecs[i].on, vecs[i].key, vecs[i].vel);
                chk("tbl_we", g_we, vecs[i].we);
                chk("tbl_we_cnt", g_we_cnt, vecs[i].we);
                if (vecs[i].we) begin
                    chk("tbl_idx", g_idx, vecs[i].idx);
                    chk("tbl_key", g_key, vecs[i].okey);
                    chk("tbl_vel", g_vel, vecs[i].ovel);
                    chk("tbl_gate", g_gate, vecs[i].gate);
                    chk("tbl_we_lat", g_we_lat, NV);
                end
                chk("tbl_rdy_lat", g_rdy_lat, NV + 1);
                chk("tbl_active", bus.active_count, vecs[i].act);
            end
        end

        // Full pool: releasing voice is reclaimed first, then steal or drop.
        do_reset();
        for (int k = 0; k < NV; k++) begin
            run_model("fill", 1'b1, 40 + k, 100);
            chk("fill_idx", g_idx, k);
        end
        run_model("full_off", 1'b0, 43, 0);
        chk("full_off_idx", g_idx, 3);
        run_model("full_reclaim", 1'b1, 50, 100);
        chk("full_reclaim_idx", g_idx, 3);
        run_model("full_last", 1'b1, 51, 100);
`ifdef VOICE_STEAL_EN
        chk("steal_we", g_we, 1);
        chk("steal_idx", g_idx, 0);
        chk("steal_drop", bus.drop_count, 0);
`else
        chk("drop_we", g_we, 0);
        chk("drop_count", bus.drop_count, 1);
`endif

        // Reset in the middle of a scan discards the event.
        wcnt = 0;
        bus.ev_valid = 1'b1; bus.ev_on = 1'b1; bus.ev_key = 7'd52; bus.ev_vel = 7'd100;
        @(posedge clk); #1;
        bus.ev_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.voice_we) wcnt++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("scan_rst_ready", bus.ev_ready, 0);
        chk("scan_rst_active", bus.active_count, 0);
        chk("scan_rst_drop", bus.drop_count, 0);
        chk("scan_rst_idx", bus.voice_idx, 0);
        chk("scan_rst_key", bus.voice_key, 0);
        chk("scan_rst_gate", bus.voice_gate, 0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("scan_rst_ready_after", bus.ev_ready, 1);
            if (bus.voice_we) wcnt++;
        end
        chk("scan_rst_no_we", wcnt, 0);
        model_clear();

        // Randomized events with done pulses issued between events.
        do_reset();
        for (int e = 0; e < 150; e++) begin
            if ($urandom_range(0, 2) == 0) begin
                d = $urandom_range(0, NV - 1);
                pulse_done(d);
                chk("rnd_done_active", bus.active_count, model_active());
            end
            r_on  = ($urandom_range(0, 9) < 7);
            r_key = 60 + $urandom_range(0, 11);
            r_vel = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            run_model("rnd", r_on, r_key, r_vel);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
